// File: rtl/writeback_pipe.sv
// Writeback stage: MEM/WB pipeline register, big-endian load extraction,
// result select, register-file/forwarding outputs, a syscall FIFO drained
// by a valid/ready console port, the sticky halt flag and a retire counter.
module writeback_pipe #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int SC_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_in,
    input  logic              flush_in,
    input  logic              valid_m,
    input  logic              reg_write_m,
    input  logic              mem_to_reg_m,
    input  logic [1:0]        ld_size_m,
    input  logic              ld_unsigned_m,
    input  logic [1:0]        addr_lo_m,
    input  logic [DATA_W-1:0] read_data_m,
    input  logic [DATA_W-1:0] alu_out_m,
    input  logic [REG_AW-1:0] write_reg_m,
    input  logic              syscall_m,
    input  logic [DATA_W-1:0] v0_m,
    input  logic [DATA_W-1:0] a0_m,
    output logic              stall_req,
    output logic              reg_write_w,
    output logic [REG_AW-1:0] write_reg_w,
    output logic [DATA_W-1:0] result_w,
    output logic              fwd_valid_w,
    output logic              sc_valid,
    input  logic              sc_ready,
    output logic [DATA_W-1:0] sc_code,
    output logic [DATA_W-1:0] sc_arg,
    output logic              halted,
    output logic [31:0]       retired
);

    localparam int PTR_W = (SC_DEPTH > 1) ? $clog2(SC_DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(SC_DEPTH);
    localparam logic [DATA_W-1:0] EXIT_CODE = DATA_W'(10);

    // MEM/WB register fields
    logic              valid_w_q, valid_w_d;
    logic              reg_write_w_q, reg_write_w_d;
    logic              mem_to_reg_w_q, mem_to_reg_w_d;
    logic [1:0]        ld_size_w_q, ld_size_w_d;
    logic              ld_unsigned_w_q, ld_unsigned_w_d;
    logic [1:0]        addr_lo_w_q, addr_lo_w_d;
    logic [DATA_W-1:0] read_data_w_q, read_data_w_d;
    logic [DATA_W-1:0] alu_out_w_q, alu_out_w_d;
    logic [REG_AW-1:0] write_reg_w_q, write_reg_w_d;

    // Control / status state
    logic              halted_q, halted_d;
    logic [31:0]       retired_q, retired_d;

    // Syscall FIFO state
    logic [DATA_W-1:0] code_mem [SC_DEPTH];
    logic [DATA_W-1:0] arg_mem  [SC_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    sc_count_q, sc_count_d;

    logic fifo_full;
    logic accept;
    logic enq;
    logic deq;

    // A syscall that finds the FIFO full must hold the whole pipe until space frees up
    always_comb begin
        fifo_full = (sc_count_q == FULL_CNT);
        stall_req = valid_m & syscall_m & fifo_full;
        accept    = ~stall_in & ~stall_req & ~halted_q;
        sc_valid  = (sc_count_q != '0);
        enq       = accept & valid_m & syscall_m & ~flush_in;
        deq       = sc_valid & sc_ready;
    end

    // Next-state for the pipeline register, halt flag, retire counter and FIFO pointers
    always_comb begin
        valid_w_d       = valid_w_q;
        reg_write_w_d   = reg_write_w_q;
        mem_to_reg_w_d  = mem_to_reg_w_q;
        ld_size_w_d     = ld_size_w_q;
        ld_unsigned_w_d = ld_unsigned_w_q;
        addr_lo_w_d     = addr_lo_w_q;
        read_data_w_d   = read_data_w_q;
        alu_out_w_d     = alu_out_w_q;
        write_reg_w_d   = write_reg_w_q;
        halted_d        = halted_q;
        retired_d       = retired_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        sc_count_d      = sc_count_q;

        if (flush_in || halted_q) begin
            valid_w_d       = 1'b0;
            reg_write_w_d   = 1'b0;
            mem_to_reg_w_d  = 1'b0;
            ld_size_w_d     = 2'b00;
            ld_unsigned_w_d = 1'b0;
            addr_lo_w_d     = 2'b00;
            read_data_w_d   = '0;
            alu_out_w_d     = '0;
            write_reg_w_d   = '0;
        end else if (!(stall_in || stall_req)) begin
            valid_w_d       = valid_m;
            reg_write_w_d   = reg_write_m;
            mem_to_reg_w_d  = mem_to_reg_m;
            ld_size_w_d     = ld_size_m;
            ld_unsigned_w_d = ld_unsigned_m;
            addr_lo_w_d     = addr_lo_m;
            read_data_w_d   = read_data_m;
            alu_out_w_d     = alu_out_m;
            write_reg_w_d   = write_reg_m;
        end

        if (enq && (v0_m == EXIT_CODE)) begin
            halted_d = 1'b1;
        end

        if (valid_w_q && !stall_in && !stall_req && !halted_q) begin
            retired_d = retired_q + 32'd1;
        end

        if (enq) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({enq, deq})
            2'b10:   sc_count_d = sc_count_q + (PTR_W + 1)'(1);
            2'b01:   sc_count_d = sc_count_q - (PTR_W + 1)'(1);
            default: sc_count_d = sc_count_q;
        endcase
    end

    // State registers with synchronous reset; reset drops the in-flight instruction and FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_w_q       <= 1'b0;
            reg_write_w_q   <= 1'b0;
            mem_to_reg_w_q  <= 1'b0;
            ld_size_w_q     <= 2'b00;
            ld_unsigned_w_q <= 1'b0;
            addr_lo_w_q     <= 2'b00;
            read_data_w_q   <= '0;
            alu_out_w_q     <= '0;
            write_reg_w_q   <= '0;
            halted_q        <= 1'b0;
            retired_q       <= 32'd0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            sc_count_q      <= '0;
        end else begin
            valid_w_q       <= valid_w_d;
            reg_write_w_q   <= reg_write_w_d;
            mem_to_reg_w_q  <= mem_to_reg_w_d;
            ld_size_w_q     <= ld_size_w_d;
            ld_unsigned_w_q <= ld_unsigned_w_d;
            addr_lo_w_q     <= addr_lo_w_d;
            read_data_w_q   <= read_data_w_d;
            alu_out_w_q     <= alu_out_w_d;
            write_reg_w_q   <= write_reg_w_d;
            halted_q        <= halted_d;
            retired_q       <= retired_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            sc_count_q      <= sc_count_d;
        end
    end

    // FIFO storage needs no reset: the count alone decides what is visible
    always_ff @(posedge clk) begin
        if (enq) begin
            code_mem[wr_ptr_q] <= v0_m;
            arg_mem[wr_ptr_q]  <= a0_m;
        end
    end

    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_value;
    int                byte_sh;

    // Big-endian sub-word extraction and the final result select
    always_comb begin
        byte_sh = 0;
        if (8 * (int'(addr_lo_w_q) + 1) <= DATA_W) begin
            byte_sh = DATA_W - 8 - 8 * int'(addr_lo_w_q);
        end
        ld_byte = 8'(read_data_w_q >> byte_sh);
        ld_half = addr_lo_w_q[1] ? read_data_w_q[15:0] : read_data_w_q[DATA_W-1 -: 16];
        case (ld_size_w_q)
            2'b01:   ld_value = {{(DATA_W - 16){~ld_unsigned_w_q & ld_half[15]}}, ld_half};
            2'b10:   ld_value = {{(DATA_W - 8){~ld_unsigned_w_q & ld_byte[7]}}, ld_byte};
            default: ld_value = read_data_w_q;
        endcase
        result_w = mem_to_reg_w_q ? ld_value : alu_out_w_q;
    end

    // Register-file, forwarding and console outputs; an empty FIFO shows zeros
    always_comb begin
        reg_write_w = valid_w_q & reg_write_w_q & (write_reg_w_q != '0);
        fwd_valid_w = reg_write_w;
        write_reg_w = write_reg_w_q;
        halted      = halted_q;
        retired     = retired_q;
        sc_code     = sc_valid ? code_mem[rd_ptr_q] : '0;
        sc_arg      = sc_valid ? arg_mem[rd_ptr_q] : '0;
    end

endmodule

// File: tb/tb_writeback_pipe.sv
// Bench for writeback_pipe: directed scenarios followed by randomized traffic,
// all compared against a queue-based reference model of the writeback stage.
module tb_writeback_pipe;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        stall_in;
    logic        flush_in;
    logic        valid_m;
    logic        reg_write_m;
    logic        mem_to_reg_m;
    logic [1:0]  ld_size_m;
    logic        ld_unsigned_m;
    logic [1:0]  addr_lo_m;
    logic [31:0] read_data_m;
    logic [31:0] alu_out_m;
    logic [4:0]  write_reg_m;
    logic        syscall_m;
    logic [31:0] v0_m;
    logic [31:0] a0_m;
    logic        stall_req;
    logic        reg_write_w;
    logic [4:0]  write_reg_w;
    logic [31:0] result_w;
    logic        fwd_valid_w;
    logic        sc_valid;
    logic        sc_ready;
    logic [31:0] sc_code;
    logic [31:0] sc_arg;
    logic        halted;
    logic [31:0] retired;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic        mValid;
    logic        mRegWrite;
    logic [4:0]  mReg;
    logic [31:0] mResult;
    logic        mHalted;
    logic [31:0] mRetired;
    logic [31:0] qCode[$];
    logic [31:0] qArg[$];

    writeback_pipe #(.DATA_W(32), .REG_AW(5), .SC_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
        .valid_m(valid_m), .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m),
        .ld_size_m(ld_size_m), .ld_unsigned_m(ld_unsigned_m), .addr_lo_m(addr_lo_m),
        .read_data_m(read_data_m), .alu_out_m(alu_out_m), .write_reg_m(write_reg_m),
        .syscall_m(syscall_m), .v0_m(v0_m), .a0_m(a0_m), .stall_req(stall_req),
        .reg_write_w(reg_write_w), .write_reg_w(write_reg_w), .result_w(result_w),
        .fwd_valid_w(fwd_valid_w), .sc_valid(sc_valid), .sc_ready(sc_ready),
        .sc_code(sc_code), .sc_arg(sc_arg), .halted(halted), .retired(retired)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it and report any difference
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive one memory-stage instruction slot
    task automatic applyStimulus(input logic v, input logic rw, input logic m2r, input logic [1:0] sz,
                                 input logic uns, input logic [1:0] lo, input logic [31:0] rd,
                                 input logic [31:0] alu, input logic [4:0] wr, input logic sys,
                                 input logic [31:0] v0, input logic [31:0] a0);
        valid_m = v; reg_write_m = rw; mem_to_reg_m = m2r; ld_size_m = sz;
        ld_unsigned_m = uns; addr_lo_m = lo; read_data_m = rd; alu_out_m = alu;
        write_reg_m = wr; syscall_m = sys; v0_m = v0; a0_m = a0;
    endtask

    task automatic applyBubble();
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0);
    endtask

    // Architectural value a load or ALU op produces, derived arithmetically
    function automatic logic [31:0] expectResult(input logic m2r, input logic [1:0] sz, input logic uns,
                                                 input logic [1:0] lo, input logic [31:0] rd,
                                                 input logic [31:0] alu);
        logic [31:0] v;
        if (!m2r) return alu;
        if (sz == 2'b01) begin
            v = lo[1] ? (rd % 32'h10000) : (rd / 32'h10000);
            if (!uns && v >= 32'h8000) v = v - 32'h10000;
        end else if (sz == 2'b10) begin
            v = (rd / (32'd1 << (8 * (3 - int'(lo))))) % 32'h100;
            if (!uns && v >= 32'h80) v = v - 32'h100;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // Advance the reference model across one clock edge using the current inputs
    task automatic modelEdge();
        logic sreq, acc, doEnq, doDeq;
        if (reset) begin
            mValid = 0; mRegWrite = 0; mReg = 0; mResult = 0;
            mHalted = 0; mRetired = 0; qCode.delete(); qArg.delete();
            return;
        end
        sreq  = valid_m && syscall_m && (qCode.size() == DEPTH);
        acc   = !stall_in && !sreq && !mHalted;
        doEnq = acc && valid_m && syscall_m && !flush_in;
        doDeq = (qCode.size() > 0) && sc_ready;
        if (mValid && !stall_in && !sreq && !mHalted) mRetired = mRetired + 1;
        if (doEnq) begin
            qCode.push_back(v0_m);
            qArg.push_back(a0_m);
        end
        if (doDeq) begin
            void'(qCode.pop_front());
            void'(qArg.pop_front());
        end
        if (flush_in || mHalted) begin
            mValid = 0; mRegWrite = 0;
        end else if (!stall_in && !sreq) begin
            mValid = valid_m; mRegWrite = reg_write_m; mReg = write_reg_m;
            mResult = expectResult(mem_to_reg_m, ld_size_m, ld_unsigned_m, addr_lo_m, read_data_m, alu_out_m);
        end
        if (doEnq && v0_m == 32'd10) mHalted = 1;
    endtask

    // One cycle: check the combinational stall, clock, update the model, check registered outputs
    task automatic stepCycle();
        logic expWr;
        #1;
        checkOutput("stall_req", 32'(stall_req), 32'(valid_m && syscall_m && (qCode.size() == DEPTH)));
        @(posedge clk);
        modelEdge();
        #1;
        expWr = mValid && mRegWrite && (mReg != 5'd0);
        checkOutput("reg_write_w", 32'(reg_write_w), 32'(expWr));
        checkOutput("fwd_valid_w", 32'(fwd_valid_w), 32'(expWr));
        if (mValid) begin
            checkOutput("write_reg_w", 32'(write_reg_w), 32'(mReg));
            checkOutput("result_w", result_w, mResult);
        end
        checkOutput("sc_valid", 32'(sc_valid), 32'(qCode.size() > 0));
        checkOutput("sc_code", sc_code, (qCode.size() > 0) ? qCode[0] : 32'h0);
        checkOutput("sc_arg", sc_arg, (qArg.size() > 0) ? qArg[0] : 32'h0);
        checkOutput("halted", 32'(halted), 32'(mHalted));
        checkOutput("retired", retired, mRetired);
    endtask

    task automatic aluOp(input logic [31:0] alu, input logic [4:0] wr);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0, alu, wr, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic loadOp(input logic [1:0] sz, input logic uns, input logic [1:0] lo);
        applyStimulus(1'b1, 1'b1, 1'b1, sz, uns, lo, 32'h80FF7F01, 32'hDEAD, 5'd9, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic syscallOp(input logic [31:0] v0, input logic [31:0] a0);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b1, v0, a0);
    endtask

    initial begin
        int drained;
        reset = 1; stall_in = 0; flush_in = 0; sc_ready = 0;
        applyBubble();
        stepCycle();
        stepCycle();
        checkOutput("rst_result_w", result_w, 32'h0);
        checkOutput("rst_write_reg_w", 32'(write_reg_w), 32'h0);
        checkOutput("rst_sc_code", sc_code, 32'h0);
        reset = 0;

        // ALU op and the four load examples
        aluOp(32'h1234, 5'd8); stepCycle();
        checkOutput("alu_result", result_w, 32'h1234);
        checkOutput("alu_reg", 32'(write_reg_w), 32'd8);
        loadOp(2'b10, 1'b0, 2'd0); stepCycle();
        checkOutput("lb_signed_0", result_w, 32'hFFFFFF80);
        loadOp(2'b10, 1'b1, 2'd3); stepCycle();
        checkOutput("lbu_3", result_w, 32'h00000001);
        loadOp(2'b01, 1'b0, 2'd2); stepCycle();
        checkOutput("lh_signed_2", result_w, 32'h00007F01);
        loadOp(2'b01, 1'b0, 2'd0); stepCycle();
        checkOutput("lh_signed_0", result_w, 32'hFFFF80FF);
        loadOp(2'b11, 1'b0, 2'd1); stepCycle();
        checkOutput("reserved_word", result_w, 32'h80FF7F01);

        // $zero write suppressed, flush gives a bubble, stall holds W for 3 cycles
        aluOp(32'h55, 5'd0); stepCycle();
        checkOutput("zero_reg_wr", 32'(reg_write_w), 32'd0);
        aluOp(32'h66, 5'd3); flush_in = 1; stepCycle(); flush_in = 0;
        checkOutput("flush_wr", 32'(reg_write_w), 32'd0);
        aluOp(32'h77, 5'd4); stepCycle();
        aluOp(32'h88, 5'd5); stall_in = 1;
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput("stall_hold", result_w, 32'h77);
        end
        stall_in = 0; stepCycle();

        // Five syscalls into a four-entry FIFO
        for (int i = 0; i < 5; i++) begin
            syscallOp(32'd1, 32'(i));
            stepCycle();
        end
        checkOutput("fifo_full_stall", 32'(stall_req), 32'd1);
        stepCycle();
        sc_ready = 1; stepCycle(); sc_ready = 0;
        stepCycle();
        applyBubble(); sc_ready = 1;
        drained = 0;
        for (int i = 0; i < 8; i++) begin
            if (sc_valid) begin
                checkOutput("drain_order", sc_arg, 32'(drained + 1));
                drained++;
            end
            stepCycle();
        end
        checkOutput("drain_count", 32'(drained), 32'd4);
        sc_ready = 0;

        // Exit syscall halts; later instructions become bubbles
        syscallOp(32'd10, 32'd7); stepCycle();
        checkOutput("halt_set", 32'(halted), 32'd1);
        checkOutput("halt_code", sc_code, 32'd10);
        for (int i = 0; i < 3; i++) begin
            aluOp(32'(100 + i), 5'd6); stepCycle();
        end
        checkOutput("halt_bubble", 32'(reg_write_w), 32'd0);

        // Reset with two FIFO entries and a valid instruction in W
        reset = 1; applyBubble(); stepCycle(); reset = 0;
        syscallOp(32'd1, 32'd20); stepCycle();
        syscallOp(32'd1, 32'd21); stepCycle();
        aluOp(32'h99, 5'd7); stepCycle();
        reset = 1; aluOp(32'hAA, 5'd7); stepCycle(); reset = 0;
        checkOutput("rst_sc_valid", 32'(sc_valid), 32'd0);
        checkOutput("rst_reg_write", 32'(reg_write_w), 32'd0);
        checkOutput("rst_retired", retired, 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic sys;
            sys = ($urandom_range(0, 5) == 0);
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                          2'($urandom), 1'($urandom), 2'($urandom), $urandom, $urandom,
                          5'($urandom_range(0, 31)), sys,
                          ($urandom_range(0, 40) == 0) ? 32'd10 : 32'($urandom_range(0, 12)),
                          $urandom);
            stall_in = ($urandom_range(0, 5) == 0);
            flush_in = ($urandom_range(0, 9) == 0);
            sc_ready = ($urandom_range(0, 2) == 0);
            reset    = ($urandom_range(0, 60) == 0);
            stepCycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
